sfx_sequencer: RTL and testbench

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

---
 rtl/sfx_pkg.sv | 45 ++++
 rtl/tick_gen.sv | 27 ++
 rtl/sfx_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer: register map, CTRL/STATUS bit
// positions, sequencer state type and the saturating sweep adder.
package sfx_pkg;

    localparam logic [3:0] ADDR_VCO1_LO  = 4'd0;
    localparam logic [3:0] ADDR_VCO1_HI  = 4'd1;
    localparam logic [3:0] ADDR_VCO2_LO  = 4'd2;
    localparam logic [3:0] ADDR_VCO2_HI  = 4'd3;
    localparam logic [3:0] ADDR_NOISE_LO = 4'd4;
    localparam logic [3:0] ADDR_NOISE_HI = 4'd5;
    localparam logic [3:0] ADDR_LFO_LO   = 4'd6;
    localparam logic [3:0] ADDR_LFO_HI   = 4'd7;
    localparam logic [3:0] ADDR_CTRL     = 4'd8;
    localparam logic [3:0] ADDR_MIXER    = 4'd9;
    localparam logic [3:0] ADDR_DURATION = 4'd10;
    localparam logic [3:0] ADDR_SWEEP    = 4'd11;
    localparam logic [3:0] ADDR_STATUS   = 4'd12;

    localparam int CTRL_VCO1_SEL      = 0;
    localparam int CTRL_VCO2_SEL      = 1;
    localparam int CTRL_NOISE_SEL     = 2;
    localparam int CTRL_LFO_SHIFT_LSB = 4;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_IRQ  = 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PLAYING = 1'b1
    } seq_state_t;

    // Adds a signed 8-bit step to a 12-bit period, clamping to [0, 4095].
    function automatic logic [11:0] sat_add12(input logic [11:0] freq, input logic [7:0] step);
        logic signed [13:0] sum;
        sum = $signed({2'b00, freq}) + $signed({{6{step[7]}}, step});
        if (sum < 14'sd0) begin
            return 12'd0;
        end else if (sum > 14'sd4095) begin
            return 12'hFFF;
        end else begin
            return sum[11:0];
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles.
module tick_gen #(
    parameter int TICK_DIV = 16000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == TERMINAL) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == TERMINAL);

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: host register file, note-duration FSM and optional vco1 sweep
// engine (compiled in with SFX_SWEEP_EN).
//   state      | meaning
//   ST_IDLE    | silent, mixer forced to 0
//   ST_PLAYING | mixer follows MIXER; counts ticks down unless DURATION was 0
module sfx_sequencer #(
    parameter int TICK_DIV = 16000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [7:0]  io_rdata,
    output logic [11:0] vco1_freq,
    output logic [11:0] vco2_freq,
    output logic [11:0] noise_freq,
    output logic [9:0]  lfo_freq,
    output logic        vco1_select,
    output logic        vco2_select,
    output logic        noise_select,
    output logic [2:0]  lfo_shift,
    output logic [3:0]  mixer,
    output logic        irq
);

    import sfx_pkg::*;

    logic       tick;
    seq_state_t state, state_next;
    logic [7:0] vco1_stage, vco2_stage, noise_stage, lfo_stage;
    logic [3:0] mixer_reg;
    logic [7:0] remaining;
    logic [7:0] sweep;
    logic       sweep_step;
    logic       busy;
    logic       wr_dur, wr_status, wr_vco1_hi, expire;
    logic [7:0] rdata_next;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign wr_dur     = io_we && (io_addr == ADDR_DURATION);
    assign wr_status  = io_we && (io_addr == ADDR_STATUS);
    assign wr_vco1_hi = io_we && (io_addr == ADDR_VCO1_HI);
    // A DURATION write landing on the final tick restarts the note instead of ending it.
    assign expire     = (state == ST_PLAYING) && tick && (remaining == 8'd1) && !wr_dur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (wr_dur) begin
            state_next = ST_PLAYING;
        end else if (expire) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        busy  = (state == ST_PLAYING);
        mixer = busy ? mixer_reg : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= 8'd0;
            irq       <= 1'b0;
        end else begin
            if (wr_dur) begin
                remaining <= io_wdata;
            end else if ((state == ST_PLAYING) && tick && (remaining != 8'd0)) begin
                remaining <= remaining - 8'd1;
            end
            if (expire) begin
                irq <= 1'b1;
            end else if (wr_status && io_wdata[STATUS_IRQ]) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef SFX_SWEEP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep <= 8'h00;
        end else if (io_we && (io_addr == ADDR_SWEEP)) begin
            sweep <= io_wdata;
        end
    end
    assign sweep_step = (state == ST_PLAYING) && tick;
`else
    assign sweep      = 8'h00;
    assign sweep_step = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vco1_stage   <= 8'h00;
            vco2_stage   <= 8'h00;
            noise_stage  <= 8'h00;
            lfo_stage    <= 8'h00;
            vco1_freq    <= 12'h000;
            vco2_freq    <= 12'h000;
            noise_freq   <= 12'h000;
            lfo_freq     <= 10'h000;
            vco1_select  <= 1'b0;
            vco2_select  <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= 3'd0;
            mixer_reg    <= 4'h0;
        end else begin
            if (io_we) begin
                case (io_addr)
                    ADDR_VCO1_LO:  vco1_stage  <= io_wdata;
                    ADDR_VCO2_LO:  vco2_stage  <= io_wdata;
                    ADDR_VCO2_HI:  vco2_freq   <= {io_wdata[3:0], vco2_stage};
                    ADDR_NOISE_LO: noise_stage <= io_wdata;
                    ADDR_NOISE_HI: noise_freq  <= {io_wdata[3:0], noise_stage};
                    ADDR_LFO_LO:   lfo_stage   <= io_wdata;
                    ADDR_LFO_HI:   lfo_freq    <= {io_wdata[1:0], lfo_stage};
                    ADDR_CTRL: begin
                        lfo_shift    <= io_wdata[CTRL_LFO_SHIFT_LSB +: 3];
                        noise_select <= io_wdata[CTRL_NOISE_SEL];
                        vco2_select  <= io_wdata[CTRL_VCO2_SEL];
                        vco1_select  <= io_wdata[CTRL_VCO1_SEL];
                    end
                    ADDR_MIXER:    mixer_reg   <= io_wdata[3:0];
                    default: ;
                endcase
            end
            // Host commit of vco1 takes priority over the sweep on a shared cycle.
            if (wr_vco1_hi) begin
                vco1_freq <= {io_wdata[3:0], vco1_stage};
            end else if (sweep_step) begin
                vco1_freq <= sat_add12(vco1_freq, sweep);
            end
        end
    end

    // DURATION reads back the live remaining-tick count.
    always_comb begin
        rdata_next = 8'h00;
        case (io_addr)
            ADDR_VCO1_LO:  rdata_next = vco1_freq[7:0];
            ADDR_VCO1_HI:  rdata_next = {4'h0, vco1_freq[11:8]};
            ADDR_VCO2_LO:  rdata_next = vco2_freq[7:0];
            ADDR_VCO2_HI:  rdata_next = {4'h0, vco2_freq[11:8]};
            ADDR_NOISE_LO: rdata_next = noise_freq[7:0];
            ADDR_NOISE_HI: rdata_next = {4'h0, noise_freq[11:8]};
            ADDR_LFO_LO:   rdata_next = lfo_freq[7:0];
            ADDR_LFO_HI:   rdata_next = {6'h00, lfo_freq[9:8]};
            ADDR_CTRL: begin
                rdata_next[CTRL_LFO_SHIFT_LSB +: 3] = lfo_shift;
                rdata_next[CTRL_NOISE_SEL]          = noise_select;
                rdata_next[CTRL_VCO2_SEL]           = vco2_select;
                rdata_next[CTRL_VCO1_SEL]           = vco1_select;
            end
            ADDR_MIXER:    rdata_next = {4'h0, mixer_reg};
            ADDR_DURATION: rdata_next = remaining;
            ADDR_SWEEP:    rdata_next = sweep;
            ADDR_STATUS: begin
                rdata_next[STATUS_IRQ]  = irq;
                rdata_next[STATUS_BUSY] = busy;
            end
            default:       rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_rdata <= 8'h00;
        end else if (io_re) begin
            io_rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer with a behavioural reference model; sweep checks
// follow SFX_SWEEP_EN.
module tb_sfx_sequencer;

    localparam int TD = 4;
`ifdef SFX_SWEEP_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  io_addr = 4'd0;
    logic [7:0]  io_wdata = 8'd0;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [7:0]  io_rdata;
    logic [11:0] vco1_freq, vco2_freq, noise_freq;
    logic [9:0]  lfo_freq;
    logic        vco1_select, vco2_select, noise_select;
    logic [2:0]  lfo_shift;
    logic [3:0]  mixer;
    logic        irq;
    logic [56:0] dut_out;

    int checks = 0;
    int errors = 0;

    sfx_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
        .vco1_freq(vco1_freq), .vco2_freq(vco2_freq), .noise_freq(noise_freq),
        .lfo_freq(lfo_freq), .vco1_select(vco1_select), .vco2_select(vco2_select),
        .noise_select(noise_select), .lfo_shift(lfo_shift), .mixer(mixer), .irq(irq)
    );

    always #5 clk = ~clk;

    assign dut_out = {vco1_freq, vco2_freq, noise_freq, lfo_freq, vco1_select, vco2_select,
                      noise_select, lfo_shift, mixer, irq};

    // Reference model: channel periods as integers, note as play flag plus tick count.
    int         m_f[4];
    logic [7:0] m_stage[4];
    logic [7:0] m_ctrl, m_sweep, m_rdata;
    logic [3:0] m_mix;
    bit         m_playing, m_irq;
    int         m_rem, m_k;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a < 4'd8) return a[0] ? 8'(m_f[a >> 1] >> 8) : 8'(m_f[a >> 1] & 255);
        case (a)
            4'd8:    return m_ctrl;
            4'd9:    return {4'd0, m_mix};
            4'd10:   return 8'(m_rem);
            4'd11:   return SWEEP_EN ? m_sweep : 8'd0;
            4'd12:   return {6'd0, m_irq, m_playing};
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [56:0] exp_out();
        return {12'(m_f[0]), 12'(m_f[1]), 12'(m_f[2]), 10'(m_f[3]), m_ctrl[0], m_ctrl[1],
                m_ctrl[2], m_ctrl[6:4], (m_playing ? m_mix : 4'd0), m_irq};
    endfunction

    function automatic bit expiring_next();
        return m_playing && (m_rem == 1) && ((m_k + 1) % TD == 0);
    endfunction

    always @(posedge clk) begin
        int  sw, v;
        bit  tick, was_playing, set_irq;
        if (reset) begin
            m_f = '{default: 0};
            m_stage = '{default: 8'd0};
            m_ctrl = 0; m_sweep = 0; m_mix = 0; m_rdata = 0;
            m_playing = 0; m_irq = 0; m_rem = 0; m_k = 0;
        end else begin
            m_k++;
            tick = (m_k % TD == 0);
            was_playing = m_playing;
            if (io_re) m_rdata = m_read(io_addr);
            if (SWEEP_EN && was_playing && tick && !(io_we && io_addr == 4'd1)) begin
                sw = $signed(m_sweep);
                v = m_f[0] + sw;
                m_f[0] = (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
            end
            if (io_we) begin
                if (io_addr < 4'd8) begin
                    if (!io_addr[0]) m_stage[io_addr >> 1] = io_wdata;
                    else m_f[io_addr >> 1] = int'(io_wdata & ((io_addr == 4'd7) ? 8'h03 : 8'h0F)) * 256
                                             + int'(m_stage[io_addr >> 1]);
                end
                case (io_addr)
                    4'd8:  m_ctrl = io_wdata & 8'h77;
                    4'd9:  m_mix = io_wdata[3:0];
                    4'd11: if (SWEEP_EN) m_sweep = io_wdata;
                    default: ;
                endcase
            end
            set_irq = 0;
            if (io_we && io_addr == 4'd10) begin
                m_playing = 1; m_rem = int'(io_wdata);
            end else if (was_playing && tick && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_playing = 0; set_irq = 1; end
            end
            if (set_irq) m_irq = 1;
            else if (io_we && io_addr == 4'd12 && io_wdata[1]) m_irq = 0;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        io_addr = a; io_re = 1'b1;
        @(negedge clk);
        io_re = 1'b0;
        d = io_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dut_out !== 57'd0) begin $display("FAIL reset_outputs: got %h want 0", dut_out); errors++; end
        checks++; if (io_rdata !== 8'd0) begin $display("FAIL reset_rdata: got %h want 00", io_rdata); errors++; end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dut_out !== exp_out()) begin $display("FAIL post_reset: got %h want %h", dut_out, exp_out()); errors++; end
        rd(4'd12, d);
        checks++; if (d !== 8'h00) begin $display("FAIL reset_status: got %h want 00", d); errors++; end
    endtask

    task automatic test_vco_write();
        logic [7:0] d;
        do_reset();
        wr(4'd0, 8'hAB);
        wr(4'd1, 8'h00);
        wr(4'd0, 8'h34);
        checks++; if (vco1_freq !== 12'h0AB) begin $display("FAIL vco1_after_lo: got %h want 0ab", vco1_freq); errors++; end
        wr(4'd1, 8'h12);
        checks++; if (vco1_freq !== 12'h234) begin $display("FAIL vco1_after_hi: got %h want 234", vco1_freq); errors++; end
        rd(4'd1, d);
        checks++; if (d !== 8'h02) begin $display("FAIL vco1_hi_read: got %h want 02", d); errors++; end
        rd(4'd0, d);
        checks++; if (d !== 8'h34) begin $display("FAIL vco1_lo_read: got %h want 34", d); errors++; end
    endtask

    task automatic test_register_map();
        logic [7:0] d;
        do_reset();
        wr(4'd8, 8'hFF);
        checks++; if ({vco1_select, vco2_select, noise_select, lfo_shift} !== 6'h3F) begin
            $display("FAIL ctrl_outputs: got %b want 111111", {vco1_select, vco2_select, noise_select, lfo_shift}); errors++; end
        rd(4'd8, d);
        checks++; if (d !== 8'h77) begin $display("FAIL ctrl_read: got %h want 77", d); errors++; end
        wr(4'd6, 8'hA5);
        wr(4'd7, 8'hFF);
        checks++; if (lfo_freq !== 10'h3A5) begin $display("FAIL lfo_commit: got %h want 3a5", lfo_freq); errors++; end
        rd(4'd7, d);
        checks++; if (d !== 8'h03) begin $display("FAIL lfo_hi_read: got %h want 03", d); errors++; end
        wr(4'd15, 8'hFF);
        rd(4'd15, d);
        checks++; if (d !== 8'h00) begin $display("FAIL reserved_read: got %h want 00", d); errors++; end
        wr(4'd9, 8'hF7);
        checks++; if (mixer !== 4'h0) begin $display("FAIL mixer_idle: got %h want 0", mixer); errors++; end
        rd(4'd9, d);
        io_addr = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (io_rdata !== 8'h07) begin $display("FAIL rdata_hold: got %h want 07", io_rdata); errors++; end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            io_we = (r < 4);
            io_re = (r >= 3 && r < 7);
            io_addr = 4'($urandom_range(0, 15));
            io_wdata = (io_addr == 4'd10) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (io_addr == 4'd10) io_re = 1'b0;
            @(negedge clk);
            checks++; if (dut_out !== exp_out()) begin $display("FAIL random_outputs: cycle %0d got %h want %h", n, dut_out, exp_out()); errors++; end
            checks++; if (io_rdata !== m_rdata) begin $display("FAIL random_rdata: cycle %0d got %h want %h", n, io_rdata, m_rdata); errors++; end
        end
        io_we = 1'b0;
        io_re = 1'b0;
    endtask

    task automatic test_note_duration();
        logic [7:0] d;
        int n;
        do_reset();
        wr(4'd9, 8'h0F);
        wr(4'd10, 8'd3);
        checks++; if (mixer !== 4'hF || irq !== 1'b0) begin $display("FAIL note_start: mixer=%h irq=%b want f/0", mixer, irq); errors++; end
        n = 0;
        while (irq !== 1'b1 && n < 8 * TD) begin
            @(negedge clk);
            n++;
            checks++; if (dut_out !== exp_out()) begin $display("FAIL note_track: got %h want %h", dut_out, exp_out()); errors++; end
        end
        checks++; if (irq !== 1'b1 || n < 2 * TD + 1 || n > 3 * TD) begin
            $display("FAIL note_length: irq=%b after %0d cycles want 1 within %0d..%0d", irq, n, 2 * TD + 1, 3 * TD); errors++; end
        checks++; if (mixer !== 4'h0) begin $display("FAIL note_end_mixer: got %h want 0", mixer); errors++; end
        rd(4'd12, d);
        checks++; if (d !== 8'h02) begin $display("FAIL note_end_status: got %h want 02", d); errors++; end
        wr(4'd12, 8'h02);
        checks++; if (irq !== 1'b0) begin $display("FAIL irq_clear: got %b want 0", irq); errors++; end
    endtask

    task automatic test_irq_race();
        int n;
        do_reset();
        wr(4'd9, 8'h05);
        wr(4'd10, 8'd1);
        for (n = 0; n < 4 * TD && !expiring_next(); n++) @(negedge clk);
        checks++; if (!expiring_next()) begin $display("FAIL race_wait: expiry not reached in %0d cycles", n); errors++; end
        wr(4'd12, 8'h02);
        checks++; if (irq !== 1'b1 || mixer !== 4'h0) begin $display("FAIL irq_set_wins: irq=%b mixer=%h want 1/0", irq, mixer); errors++; end
        wr(4'd12, 8'h02);
        checks++; if (irq !== 1'b0) begin $display("FAIL irq_clear_after: got %b want 0", irq); errors++; end
    endtask

    task automatic test_back_to_back();
        int n, ticks;
        do_reset();
        wr(4'd9, 8'h0A);
        wr(4'd10, 8'd2);
        for (n = 0; n < 8 * TD && !expiring_next(); n++) @(negedge clk);
        checks++; if (!expiring_next()) begin $display("FAIL b2b_wait: expiry not reached in %0d cycles", n); errors++; end
        wr(4'd10, 8'd5);
        checks++; if (mixer !== 4'hA || irq !== 1'b0) begin $display("FAIL b2b_restart: mixer=%h irq=%b want a/0", mixer, irq); errors++; end
        ticks = 0;
        for (n = 0; n < 10 * TD && mixer !== 4'h0; n++) begin
            @(negedge clk);
            if (m_k % TD == 0) ticks++;
            checks++; if (irq !== 1'b0 && mixer !== 4'h0) begin $display("FAIL b2b_early_irq: irq=%b mixer=%h", irq, mixer); errors++; end
        end
        checks++; if (ticks != 5 || irq !== 1'b1) begin $display("FAIL b2b_length: ticks=%0d irq=%b want 5/1", ticks, irq); errors++; end
    endtask

    task automatic test_continuous();
        logic [7:0] d;
        int n;
        do_reset();
        wr(4'd9, 8'h03);
        wr(4'd10, 8'd0);
        for (n = 0; n < 1000 * TD; n++) begin
            @(negedge clk);
            checks++;
            if (mixer !== 4'h3 || irq !== 1'b0) begin
                $display("FAIL cont_playing: cycle %0d mixer=%h irq=%b want 3/0", n, mixer, irq); errors++;
                break;
            end
        end
        wr(4'd9, 8'h00);
        rd(4'd12, d);
        checks++; if (d !== 8'h01 || mixer !== 4'h0) begin $display("FAIL mixer_zero_busy: status=%h mixer=%h want 01/0", d, mixer); errors++; end
        wr(4'd9, 8'h03);
        checks++; if (mixer !== 4'h3) begin $display("FAIL mixer_restore: got %h want 3", mixer); errors++; end
        wr(4'd10, 8'd1);
        for (n = 0; n < 4 * TD && irq !== 1'b1; n++) @(negedge clk);
        checks++; if (irq !== 1'b1 || mixer !== 4'h0) begin $display("FAIL cont_stop: irq=%b mixer=%h want 1/0", irq, mixer); errors++; end
    endtask

    task automatic test_reset_mid_note();
        logic [7:0] d;
        do_reset();
        wr(4'd2, 8'h55);
        wr(4'd3, 8'h05);
        wr(4'd8, 8'h17);
        wr(4'd9, 8'h0F);
        rd(4'd3, d);
        wr(4'd10, 8'd10);
        repeat (5) @(negedge clk);
        checks++; if (mixer !== 4'hF || io_rdata !== 8'h05) begin $display("FAIL pre_reset_note: mixer=%h rdata=%h want f/05", mixer, io_rdata); errors++; end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dut_out !== 57'd0 || io_rdata !== 8'h00) begin $display("FAIL reset_mid_note: out=%h rdata=%h want 0/00", dut_out, io_rdata); errors++; end
        reset = 1'b0;
        rd(4'd12, d);
        checks++; if (d !== 8'h00) begin $display("FAIL reset_mid_status: got %h want 00", d); errors++; end
    endtask

    task automatic test_sweep();
        logic [7:0] d;
        int n, i;
`ifdef SFX_SWEEP_EN
        int up[5] = '{4094, 4095, 4095, 4095, 4095};
        int dn[3] = '{2, 0, 0};
        do_reset();
        wr(4'd0, 8'hFA);
        wr(4'd1, 8'h0F);
        wr(4'd11, 8'h04);
        rd(4'd11, d);
        checks++; if (d !== 8'h04) begin $display("FAIL sweep_read: got %h want 04", d); errors++; end
        wr(4'd10, 8'd5);
        i = 0;
        for (n = 0; n < 8 * TD && i < 5; n++) begin
            @(negedge clk);
            if (m_k % TD == 0) begin
                checks++; if (vco1_freq !== 12'(up[i])) begin $display("FAIL sweep_up: tick %0d got %0d want %0d", i, vco1_freq, up[i]); errors++; end
                i++;
            end
        end
        checks++; if (i != 5) begin $display("FAIL sweep_up_wait: saw %0d ticks want 5", i); errors++; end
        wr(4'd0, 8'h06);
        wr(4'd1, 8'h00);
        wr(4'd11, 8'hFC);
        wr(4'd10, 8'd3);
        i = 0;
        for (n = 0; n < 6 * TD && i < 3; n++) begin
            @(negedge clk);
            if (m_k % TD == 0) begin
                checks++; if (vco1_freq !== 12'(dn[i])) begin $display("FAIL sweep_down: tick %0d got %0d want %0d", i, vco1_freq, dn[i]); errors++; end
                i++;
            end
        end
        checks++; if (i != 3) begin $display("FAIL sweep_down_wait: saw %0d ticks want 3", i); errors++; end
        wr(4'd0, 8'h00);
        wr(4'd11, 8'h10);
        wr(4'd10, 8'd0);
        for (n = 0; n < 4 * TD && ((m_k + 1) % TD != 0); n++) @(negedge clk);
        wr(4'd1, 8'h08);
        checks++; if (vco1_freq !== 12'h800) begin $display("FAIL hi_beats_sweep: got %h want 800", vco1_freq); errors++; end
        for (n = 0; n < 2 * TD && (m_k % TD != 0); n++) @(negedge clk);
        checks++; if (vco1_freq !== 12'h810) begin $display("FAIL sweep_after_hi: got %h want 810", vco1_freq); errors++; end
`else
        do_reset();
        wr(4'd11, 8'h04);
        rd(4'd11, d);
        checks++; if (d !== 8'h00) begin $display("FAIL sweep_absent_read: got %h want 00", d); errors++; end
        wr(4'd0, 8'h00);
        wr(4'd1, 8'h01);
        wr(4'd10, 8'd2);
        for (n = 0; n < 3 * TD; n++) @(negedge clk);
        i = 0;
        checks++; if (vco1_freq !== 12'h100) begin $display("FAIL sweep_absent_freq: got %h want 100 (%0d)", vco1_freq, i); errors++; end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vco_write();
        test_register_map();
        test_note_duration();
        test_irq_race();
        test_back_to_back();
        test_sweep();
        test_reset_mid_note();
        test_continuous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
